// File: rtl/memory_view_arbiter.sv
// Shares the instruction_memory read port between a CPU requester and the memory viewer,
// fetching the next text row's word once per scan line and rendering address/data bits.
module memory_view_arbiter #(
  parameter int unsigned ADDRESS_WIDTH  = 11,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned V_TOTAL        = 525,
  parameter int unsigned FETCH_X        = 640,
  parameter int unsigned ROW_FIRST      = 3,
  parameter int unsigned ROW_LAST       = 12,
  parameter int unsigned ADDR_COL_FIRST = 2,
  parameter int unsigned DATA_COL_FIRST = 20,
  parameter int unsigned BASE_ADDRESS   = 0
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic [9:0]               pixel_x_in,
  input  logic [9:0]               pixel_y_in,
  output logic [ADDRESS_WIDTH-1:0] mem_address_out,
  input  logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic                     cpu_req_in,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address_in,
  output logic                     cpu_grant_out,
  output logic                     cpu_valid_out,
  output logic [DATA_WIDTH-1:0]    cpu_data_out,
  output logic                     bit_value_out
);

  localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    D_ISSUE,
    D_CAPTURE,
    C_ISSUE,
    C_CAPTURE
  } state_t;

  state_t                   state;
  state_t                   state_next;
  state_t                   arb_next;
  logic [9:0]               prev_x;
  logic                     trigger;
  logic                     fetch_trigger;
  logic                     last_line;
  logic [5:0]               nrow;
  logic                     nrow_in_window;
  logic [ADDRESS_WIDTH-1:0] fetch_addr;
  logic [ADDRESS_WIDTH-1:0] pend_addr;
  logic                     pending;
  logic [DATA_WIDTH-1:0]    next_word;
  logic [DATA_WIDTH-1:0]    display_word;
  logic [DATA_WIDTH-1:0]    cpu_data_q;

  logic [5:0]               row;
  logic [6:0]               col;
  logic [6:0]               addr_off;
  logic [6:0]               data_off;
  logic [IW-1:0]            addr_idx;
  logic [IW-1:0]            data_idx;
  logic [DATA_WIDTH-1:0]    row_word;

  function automatic logic row_in_window(input logic [5:0] r);
    return (r >= 6'(ROW_FIRST)) && (r <= 6'(ROW_LAST));
  endfunction

  function automatic logic [ADDRESS_WIDTH-1:0] row_address(input logic [5:0] r);
    return ADDRESS_WIDTH'(BASE_ADDRESS) + ADDRESS_WIDTH'(r) - ADDRESS_WIDTH'(ROW_FIRST);
  endfunction

  // Fetch trigger: first pixel of h-blank, looking one line ahead (with frame wrap).
  assign trigger        = (pixel_x_in == 10'(FETCH_X)) && (prev_x != 10'(FETCH_X));
  assign last_line      = (pixel_y_in == 10'(V_TOTAL - 1));
  assign nrow           = last_line ? 6'd0 : 6'((pixel_y_in + 10'd1) >> 4);
  assign nrow_in_window = row_in_window(nrow);
  assign fetch_trigger  = trigger && nrow_in_window;
  assign fetch_addr     = row_address(nrow);

  // Capture states arbitrate exactly like IDLE so back-to-back transactions lose no cycle.
  always_comb begin
    arb_next = IDLE;
    if (pending || fetch_trigger) begin
      arb_next = D_ISSUE;
    end else if (cpu_req_in) begin
      arb_next = C_ISSUE;
    end

    state_next = state;
    case (state)
      IDLE, D_CAPTURE, C_CAPTURE: state_next = arb_next;
      D_ISSUE:                    state_next = D_CAPTURE;
      C_ISSUE:                    state_next = C_CAPTURE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      prev_x          <= '0;
      pending         <= 1'b0;
      pend_addr       <= '0;
      mem_address_out <= '0;
      next_word       <= '0;
      display_word    <= '0;
      cpu_data_q      <= '0;
    end else begin
      prev_x <= pixel_x_in;

      if (fetch_trigger) begin
        pending   <= 1'b1;
        pend_addr <= fetch_addr;
      end else if (state == D_ISSUE) begin
        pending <= 1'b0;
      end

      if (state_next == D_ISSUE) begin
        mem_address_out <= fetch_trigger ? fetch_addr : pend_addr;
      end else if (state_next == C_ISSUE) begin
        mem_address_out <= cpu_address_in;
      end

      if (state == D_CAPTURE) begin
        next_word <= mem_data_in;
      end else if (trigger && !nrow_in_window) begin
        next_word <= '0;
      end

      if (state == C_CAPTURE) begin
        cpu_data_q <= mem_data_in;
      end

      if ((pixel_x_in == 10'd0) && (prev_x != 10'd0)) begin
        display_word <= next_word;
      end
    end
  end

  assign cpu_grant_out = (state == C_ISSUE);
  assign cpu_valid_out = (state == C_CAPTURE);
  assign cpu_data_out  = cpu_valid_out ? mem_data_in : cpu_data_q;

  // Character rendering: MSB sits in the leftmost column of each field.
  assign row      = pixel_y_in[9:4];
  assign col      = pixel_x_in[9:3];
  assign addr_off = col - 7'(ADDR_COL_FIRST);
  assign data_off = col - 7'(DATA_COL_FIRST);
  assign addr_idx = IW'(DATA_WIDTH - 1) - addr_off[IW-1:0];
  assign data_idx = IW'(DATA_WIDTH - 1) - data_off[IW-1:0];
  assign row_word = DATA_WIDTH'(row_address(row));

  always_comb begin
    bit_value_out = 1'b0;
    if (row_in_window(row)) begin
      if ((col >= 7'(ADDR_COL_FIRST)) && (addr_off < 7'(DATA_WIDTH))) begin
        bit_value_out = row_word[addr_idx];
      end else if ((col >= 7'(DATA_COL_FIRST)) && (data_off < 7'(DATA_WIDTH))) begin
        bit_value_out = display_word[data_idx];
      end
    end
  end

endmodule

// File: tb/tb_memory_view_arbiter.sv
// Directed bench for memory_view_arbiter: rendering vector table plus arbitration,
// contention, out-of-window and reset sequences against a synchronous memory model.
module tb_memory_view_arbiter;

  logic        clock_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic [9:0]  pixel_x_in = 10'd100;
  logic [9:0]  pixel_y_in = 10'd100;
  logic [10:0] mem_address_out;
  logic [15:0] mem_data_in = 16'h0000;
  logic        cpu_req_in = 1'b0;
  logic [10:0] cpu_address_in = 11'd0;
  logic        cpu_grant_out;
  logic        cpu_valid_out;
  logic [15:0] cpu_data_out;
  logic        bit_value_out;

  int checks = 0;
  int fails  = 0;

  memory_view_arbiter #(
    .ADDRESS_WIDTH (11),
    .DATA_WIDTH    (16),
    .V_TOTAL       (525),
    .FETCH_X       (640),
    .ROW_FIRST     (3),
    .ROW_LAST      (12),
    .ADDR_COL_FIRST(2),
    .DATA_COL_FIRST(20),
    .BASE_ADDRESS  (0)
  ) dut (
    .clock_in       (clock_in),
    .reset_n_in     (reset_n_in),
    .pixel_x_in     (pixel_x_in),
    .pixel_y_in     (pixel_y_in),
    .mem_address_out(mem_address_out),
    .mem_data_in    (mem_data_in),
    .cpu_req_in     (cpu_req_in),
    .cpu_address_in (cpu_address_in),
    .cpu_grant_out  (cpu_grant_out),
    .cpu_valid_out  (cpu_valid_out),
    .cpu_data_out   (cpu_data_out),
    .bit_value_out  (bit_value_out)
  );

  always #5 clock_in = ~clock_in;

  // Synchronous memory: word[a] = a * 16'h1111.
  always @(posedge clock_in) mem_data_in <= 16'(mem_address_out) * 16'h1111;

  typedef struct {
    int   y_prev;
    int   x;
    logic exp;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // Compressed scan line: trigger at x=640 on line yp, then x=0 on the following line.
  task automatic run_line(input int yp);
    pixel_y_in = 10'(yp);
    pixel_x_in = 10'd639;
    tick();
    for (int x = 640; x <= 650; x++) begin
      pixel_x_in = 10'(x);
      tick();
    end
    pixel_y_in = (yp == 524) ? 10'd0 : 10'(yp + 1);
    pixel_x_in = 10'd0;
    tick();
  endtask

  task automatic probe(input string name, input int x, input logic exp);
    pixel_x_in = 10'(x);
    #1;
    check(name, 32'(bit_value_out), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g;

    vecs[0]  = '{47, 160, 1'b0};
    vecs[1]  = '{47, 136, 1'b0};
    vecs[2]  = '{79, 160, 1'b0};
    vecs[3]  = '{79, 176, 1'b1};
    vecs[4]  = '{79, 275, 1'b1};
    vecs[5]  = '{79, 280, 1'b0};
    vecs[6]  = '{79, 128, 1'b1};
    vecs[7]  = '{79, 136, 1'b0};
    vecs[8]  = '{191, 160, 1'b1};
    vecs[9]  = '{191, 168, 1'b0};
    vecs[10] = '{191, 287, 1'b1};
    vecs[11] = '{191, 288, 1'b0};
    vecs[12] = '{191, 152, 1'b0};
    vecs[13] = '{191, 112, 1'b1};
    vecs[14] = '{191, 120, 1'b0};
    vecs[15] = '{191, 16, 1'b0};
    vecs[16] = '{207, 128, 1'b0};
    vecs[17] = '{31, 176, 1'b0};
    vecs[18] = '{63, 184, 1'b1};
    vecs[19] = '{63, 176, 1'b0};
    vecs[20] = '{63, 136, 1'b1};

    // Reset state
    pixel_y_in = 10'd80;
    pixel_x_in = 10'd176;
    tick();
    tick();
    check("rst_addr", 32'(mem_address_out), 32'd0);
    check("rst_grant", 32'(cpu_grant_out), 32'd0);
    check("rst_valid", 32'(cpu_valid_out), 32'd0);
    check("rst_data", 32'(cpu_data_out), 32'd0);
    check("rst_bit", 32'(bit_value_out), 32'd0);
    reset_n_in = 1'b1;

    // Uncontended CPU read
    pixel_x_in = 10'd100;
    pixel_y_in = 10'd100;
    cpu_req_in = 1'b1;
    cpu_address_in = 11'd5;
    tick();
    check("a_grant", 32'(cpu_grant_out), 32'd1);
    check("a_addr", 32'(mem_address_out), 32'd5);
    cpu_req_in = 1'b0;
    tick();
    check("a_valid", 32'(cpu_valid_out), 32'd1);
    check("a_data", 32'(cpu_data_out), 32'h5555);
    check("a_grant_low", 32'(cpu_grant_out), 32'd0);
    tick();
    check("a_valid_low", 32'(cpu_valid_out), 32'd0);
    check("a_data_held", 32'(cpu_data_out), 32'h5555);

    // Rendering table
    for (int i = 0; i < 21; i++) begin
      run_line(vecs[i].y_prev);
      probe($sformatf("vec%0d", i), vecs[i].x, vecs[i].exp);
    end

    // Out-of-window triggers issue no fetch
    run_line(191);
    check("oow_addr_191", 32'(mem_address_out), 32'd9);
    run_line(524);
    check("oow_addr_524", 32'(mem_address_out), 32'd9);
    check("oow_wrap_y", 32'(pixel_y_in), 32'd0);
    run_line(207);
    check("oow_addr_207", 32'(mem_address_out), 32'd9);
    pixel_y_in = 10'd208;
    probe("oow_row13_addr", 128, 1'b0);
    probe("oow_row13_data", 160, 1'b0);

    // CPU request arrives together with the trigger: display goes first
    pixel_y_in = 10'd47;
    pixel_x_in = 10'd639;
    tick();
    pixel_x_in = 10'd640;
    cpu_req_in = 1'b1;
    cpu_address_in = 11'd7;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n = k;
      if (k == 1) check("b_disp_addr", 32'(mem_address_out), 32'd0);
      if (cpu_grant_out) break;
      pixel_x_in = pixel_x_in + 10'd1;
    end
    check("b_grant_cycles", 32'(n), 32'd3);
    check("b_grant_addr", 32'(mem_address_out), 32'd7);
    cpu_req_in = 1'b0;
    pixel_x_in = pixel_x_in + 10'd1;
    tick();
    check("b_valid", 32'(cpu_valid_out), 32'd1);
    check("b_data", 32'(cpu_data_out), 32'h7777);
    for (int k = 0; k < 6; k++) begin
      pixel_x_in = pixel_x_in + 10'd1;
      tick();
    end
    pixel_y_in = 10'd48;
    pixel_x_in = 10'd0;
    tick();
    probe("b_row3_data", 160, 1'b0);

    // Trigger lands while the CPU read is in C_ISSUE
    pixel_y_in = 10'd79;
    pixel_x_in = 10'd639;
    cpu_req_in = 1'b1;
    cpu_address_in = 11'd3;
    tick();
    check("c_grant", 32'(cpu_grant_out), 32'd1);
    pixel_x_in = 10'd640;
    cpu_req_in = 1'b0;
    tick();
    check("c_valid", 32'(cpu_valid_out), 32'd1);
    check("c_data", 32'(cpu_data_out), 32'h3333);
    pixel_x_in = 10'd641;
    tick();
    check("c_disp_addr", 32'(mem_address_out), 32'd2);
    check("c_grant_low", 32'(cpu_grant_out), 32'd0);
    pixel_x_in = 10'd642;
    tick();
    pixel_x_in = 10'd643;
    tick();
    pixel_y_in = 10'd80;
    pixel_x_in = 10'd0;
    tick();
    probe("c_row5_col22", 176, 1'b1);
    probe("c_row5_col20", 160, 1'b0);
    probe("c_row5_col34", 272, 1'b1);

    // Reset during C_CAPTURE aborts the read
    pixel_y_in = 10'd100;
    pixel_x_in = 10'd100;
    cpu_req_in = 1'b1;
    cpu_address_in = 11'd6;
    tick();
    cpu_req_in = 1'b0;
    tick();
    check("d_pre_valid", 32'(cpu_valid_out), 32'd1);
    reset_n_in = 1'b0;
    #1;
    check("d_valid", 32'(cpu_valid_out), 32'd0);
    check("d_data", 32'(cpu_data_out), 32'd0);
    check("d_addr", 32'(mem_address_out), 32'd0);
    check("d_grant", 32'(cpu_grant_out), 32'd0);
    pixel_y_in = 10'd80;
    probe("d_display_clear", 176, 1'b0);
    g = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (cpu_valid_out) g++;
    end
    check("d_no_valid", 32'(g), 32'd0);
    reset_n_in = 1'b1;
    run_line(79);
    probe("d_after_reset", 176, 1'b1);
    check("d_data_still0", 32'(cpu_data_out), 32'd0);

    // Continuous CPU demand alongside display fetches
    pixel_y_in = 10'd100;
    pixel_x_in = 10'd100;
    cpu_req_in = 1'b1;
    cpu_address_in = 11'd4;
    g = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (cpu_grant_out) g++;
    end
    check("e_grant_rate", 32'(g), 32'd5);
    run_line(63);
    probe("e_row4_col23", 184, 1'b1);
    probe("e_row4_col22", 176, 1'b0);
    cpu_req_in = 1'b0;
    tick();
    tick();
    tick();
    check("e_cpu_data", 32'(cpu_data_out), 32'h4444);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
